serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b`. It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the sequential counterpart of the datapath's full-adder cells and trades latency for area in narrow arithmetic paths. Operands are loaded on a start pulse; a one-cycle done strobe flags a valid result.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.

Ports:
- `clk`, input, 1: the single clock; every register updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request to begin; sampled only when not busy.
- `a`, input, `WIDTH`: minuend; captured in the cycle `start` is accepted.
- `b`, input, `WIDTH`: subtrahend; captured in the same cycle as `a`.
- `busy`, output, 1: high while an operation is in progress (RUN state).
- `done`, output, 1: one-cycle strobe; `diff`/`borrow_out` are valid from this cycle onward.
- `diff`, output, `WIDTH`: result, `a - b` mod 2^`WIDTH`.
- `borrow_out`, output, 1: final borrow; 1 iff `a < b` unsigned.
- `overflow`, output, 1: signed overflow flag; only present with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:** with `start` = 1 at an edge:
  - load shift registers `sa ← a`, `sb ← b`;
  - clear the borrow flip-flop `br ← 0` and the bit counter `cnt ← 0`;
  - go to RUN.
- **RUN:** each cycle:
  - compute `d = sa[0] ^ sb[0] ^ br`;
  - compute `br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`;
  - shift `d` into the MSB of the result register, which shifts right;
  - shift `sa` and `sb` right by one;
  - increment `cnt`.
  - At `cnt == WIDTH-1`, the final bit is processed and the FSM goes to DONE.
- **DONE:** `done` = 1 for exactly one cycle; `borrow_out ← br`.
  - If `start` = 1 in DONE, it is accepted exactly as in IDLE (back-to-back operation) and the FSM goes to RUN.
  - Otherwise the FSM goes to IDLE.
- `start` is ignored in RUN; there is no queuing and no error indication.
- `diff` and `borrow_out` hold their last result until the next operation's DONE.
  - During RUN, the result register is internal; `diff` is driven from a separate output register, or from the shift register gated so it changes only at DONE.
- `cnt` is `$clog2(WIDTH)` bits wide and wraps naturally; only the `WIDTH-1` compare is used.
- Reset mid-operation aborts immediately: the FSM goes to IDLE and all outputs are cleared.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `diff` = 0, `borrow_out` = 0, `overflow` = 0;
  - FSM in IDLE, `cnt` = 0, `br` = 0.
- Start accepted at edge T: `busy` rises after T; RUN covers edges T+1 … T+`WIDTH`.
- `done` is high in the cycle after edge T+`WIDTH`. Latency from start to done is `WIDTH`+1 edges.
- Throughput: one result per `WIDTH`+1 cycles with back-to-back starts.
- `busy` and `done` are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:**
  - capture `a[WIDTH-1]` and `b[WIDTH-1]` at load;
  - at DONE, set `overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb)`;
  - `overflow` holds with `diff` and resets to 0.
- **Undefined:** the `overflow` port and its MSB registers are absent; all other behaviour is identical.

## Structure
- Shared package `serial_arith_pkg`:
  - FSM state enum (IDLE, RUN, DONE);
  - `SERIAL_WIDTH_DEFAULT` = 8;
  - this package is shared with a future bit-serial adder.
- Sub-module `full_subtractor_cell`: combinational, with inputs `x`, `y`, `bin` and outputs `d`, `bout`. It is instantiated once.
- Everything else lives in the top module.

## Test plan
All scenarios use `WIDTH` = 8.
- `a`=0x05, `b`=0x03, start pulse → `done` exactly 9 edges later; `diff`=0x02, `borrow_out`=0; `busy` high for 8 cycles.
- `a`=0x03, `b`=0x05 → `diff`=0xFE, `borrow_out`=1; with `SERIAL_SUB_OVF_EN`, `overflow`=0.
- `a`=0x80, `b`=0x01 → `diff`=0x7F, `borrow_out`=0, `overflow`=1. Also `a`=0x7F, `b`=0xFF → `diff`=0x80, `overflow`=1.
- `a`=0x00, `b`=0x00, then `start` held high through DONE with new `a`=0xFF, `b`=0x01:
  - first result is `diff`=0x00, `borrow_out`=0;
  - second operation is accepted in the DONE cycle and yields `diff`=0xFE, `borrow_out`=0.
- Pulse `start` with `a`=0x11, `b`=0x22 during the 4th RUN cycle of operation 0x10-0x01 → the pulse is ignored; result `diff`=0x0F, and no second `done` appears.
- Assert `rst_n`=0 during the 5th RUN cycle → `busy`, `done`, `diff` and `borrow_out` go to 0 immediately. After release, 0xFF-0xFF → `diff`=0x00, `borrow_out`=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
package serial_arith_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_e;

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bin, with the borrow out.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (a - b), LSB first, one bit per clock through one full-subtractor cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor_cell u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            // DONE accepts start exactly like IDLE, giving back-to-back operation.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                res_d = {cell_d, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = cell_bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Publish on the final bit so the result is visible in the DONE cycle.
                    state_d = DONE;
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (amsb_q != bmsb_q) && (cell_d != amsb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would create ordering races.
    // NOTE: the shift registers are reset too; there are few of them and it keeps post-reset state fully known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = ovf_q;
`endif

endmodule
